// File: rtl/ad_bus_pkg.sv
// ad_bus_pkg: shared definitions for the multiplexed AD bus initiator.
//   - default bus width and data-phase timeout
//   - FSM state type (2-bit) and state constants
//   - active levels of the bus strobes and the pad output enable
package ad_bus_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_TIMEOUT = 15;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t ADDR = 2'd1;
  localparam state_t DATA = 2'd2;
  localparam state_t TURN = 2'd3;

  // Active levels: rd_n, wr_n and the bufif0 enable are all active low.
  localparam logic RD_ACT = 1'b0;
  localparam logic WR_ACT = 1'b0;
  localparam logic OE_ACT = 1'b0;

endpackage

// File: rtl/ad_bus_if.sv
// ad_bus_if: bundles the request/response handshake of the local register
// master together with the AD bus pad-ring signals.
//   modport slave  : the initiator's view (accepts requests, drives the bus)
//   modport master : the environment's view (issues requests, plays target)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is only ever 1 while the initiator is idle.
// rsp_valid is a single-cycle strobe; rsp_err and rsp_rdata qualify it.
interface ad_bus_if import ad_bus_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_err;
  logic [WIDTH-1:0] rsp_rdata;
  logic [WIDTH-1:0] ad_out;
  logic             ad_oe_n;
  logic [WIDTH-1:0] ad_in;
  logic             ale;
  logic             rd_n;
  logic             wr_n;
  logic             ack;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, ad_in, ack,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
           ad_out, ad_oe_n, ale, rd_n, wr_n
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, ad_in, ack,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
           ad_out, ad_oe_n, ale, rd_n, wr_n
  );

endinterface

// File: rtl/ad_bus_wait_timer.sv
// ad_bus_wait_timer: counts data-phase cycles and flags the timeout.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear_i      : zero the count (asserted the cycle before the data phase)
//   enable_i     : one data-phase cycle elapses this cycle
//   expired_o    : this enabled cycle brings the count to TIMEOUT
module ad_bus_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of completed data cycles, so the cycle in which
  // it reads TIMEOUT-1 is the TIMEOUT-th one: the count reaches TIMEOUT now.
  assign expired_o = enable_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/ad_bus_initiator.sv
// ad_bus_initiator: runs one multiplexed AD bus transaction at a time.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : request/response handshake and AD bus pins (slave view)
//   dbg_state_o  : current FSM state
// Sequence: IDLE -> ADDR (ale, address driven) -> DATA (strobe until ack or
// timeout) -> TURN (bus released, rsp_valid) -> IDLE. Every output is a flop.
module ad_bus_initiator import ad_bus_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic   clk,
  input  logic   reset_n,
  ad_bus_if.slave bus,
  output state_t dbg_state_o
);

  state_t           state_q, state_d;
  logic             wr_q, wr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [WIDTH-1:0] ad_out_q, ad_out_d;
  logic             ad_oe_n_q, ad_oe_n_d;
  logic             ale_q, ale_d;
  logic             rd_n_q, rd_n_d;
  logic             wr_n_q, wr_n_d;

  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  ad_bus_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    ad_out_d    = ad_out_q;
    ad_oe_n_d   = ad_oe_n_q;
    ale_d       = ale_q;
    rd_n_d      = rd_n_q;
    wr_n_d      = wr_n_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        // req_ready_q gates acceptance so the first edge after reset only
        // raises ready. The address goes straight into the bus register.
        if (bus.req_valid && req_ready_q) begin
          wr_d        = bus.req_write;
          wdata_d     = bus.req_wdata;
          req_ready_d = 1'b0;
          ad_out_d    = bus.req_addr;
          ad_oe_n_d   = OE_ACT;
          ale_d       = 1'b1;
          state_d     = ADDR;
        end
      end

      ADDR: begin
        timer_clear = 1'b1;
        ale_d       = 1'b0;
        state_d     = DATA;
        if (wr_q) begin
          ad_out_d  = wdata_q;
          ad_oe_n_d = OE_ACT;
          wr_n_d    = WR_ACT;
        end else begin
          // Release the pads before asserting rd_n so the target never
          // fights the initiator.
          ad_oe_n_d = ~OE_ACT;
          rd_n_d    = RD_ACT;
        end
      end

      DATA: begin
        timer_en = 1'b1;
        // ack has priority, so an ack in the last allowed cycle succeeds.
        if (bus.ack || timer_expired) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = ~bus.ack;
          rsp_rdata_d = (bus.ack && !wr_q) ? bus.ad_in : '0;
          ad_oe_n_d   = ~OE_ACT;
          rd_n_d      = ~RD_ACT;
          wr_n_d      = ~WR_ACT;
          state_d     = TURN;
        end
      end

      TURN: begin
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      ad_out_q    <= '0;
      ad_oe_n_q   <= ~OE_ACT;
      ale_q       <= 1'b0;
      rd_n_q      <= ~RD_ACT;
      wr_n_q      <= ~WR_ACT;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      ad_out_q    <= ad_out_d;
      ad_oe_n_q   <= ad_oe_n_d;
      ale_q       <= ale_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.ad_out    = ad_out_q;
  assign bus.ad_oe_n   = ad_oe_n_q;
  assign bus.ale       = ale_q;
  assign bus.rd_n      = rd_n_q;
  assign bus.wr_n      = wr_n_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ad_bus_initiator.sv
// tb_ad_bus_initiator: directed bench for ad_bus_initiator (TIMEOUT=15).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_ad_bus_initiator;
  import ad_bus_pkg::*;

  logic   clk;
  logic   reset_n;
  state_t dbg_state;
  int     checks;
  int     failures;

  ad_bus_if #(.WIDTH(32)) bus ();

  ad_bus_initiator #(.WIDTH(32), .TIMEOUT(15)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = data;
  endtask

  // Bus-protocol exclusions checked on every falling edge.
  always @(negedge clk) begin
    chk1("rd_wr_exclusive", bus.rd_n | bus.wr_n, 1'b1);
    chk1("oe_rd_exclusive", bus.ad_oe_n | bus.rd_n, 1'b1);
  end

  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_data [3];
  logic [31:0] b2b_rexp [3];

  // ---------------- directed sequence ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.ad_in     = '0;
    bus.ack       = 1'b0;
    b2b_addr = '{32'h0000_0100, 32'h0000_0204, 32'h0000_0308};
    b2b_data = '{32'h1111_2222, 32'h0, 32'h5555_6666};
    b2b_rexp = '{32'h0, 32'h3333_4444, 32'h0};

    // Reset held for 3 cycles.
    #2 reset_n = 1'b0;
    step(); step(); step();
    chk1("rst_req_ready", bus.req_ready, 1'b0);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("rst_rsp_err",   bus.rsp_err,   1'b0);
    chk ("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk ("rst_ad_out",    bus.ad_out,    32'h0);
    chk1("rst_ad_oe_n",   bus.ad_oe_n,   1'b1);
    chk1("rst_ale",       bus.ale,       1'b0);
    chk1("rst_rd_n",      bus.rd_n,      1'b1);
    chk1("rst_wr_n",      bus.wr_n,      1'b1);
    chk ("rst_state",     32'(dbg_state), 32'(IDLE));
    reset_n = 1'b1;
    step();
    chk1("ready_after_reset", bus.req_ready, 1'b1);

    // Zero-wait write.
    drive_req(1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
    step();                                   // E0: accepted
    bus.req_valid = 1'b0;
    bus.ack       = 1'b1;                     // ignored during ADDR
    chk1("wr_ale",       bus.ale,       1'b1);
    chk ("wr_ad_addr",   bus.ad_out,    32'h0000_1000);
    chk1("wr_oe_addr",   bus.ad_oe_n,   1'b0);
    chk1("wr_ready_low", bus.req_ready, 1'b0);
    step();                                   // E1: DATA
    chk1("wr_ale_pulse", bus.ale,       1'b0);
    chk1("wr_wr_n",      bus.wr_n,      1'b0);
    chk1("wr_oe_data",   bus.ad_oe_n,   1'b0);
    chk ("wr_ad_data",   bus.ad_out,    32'hDEAD_BEEF);
    chk1("wr_no_rsp",    bus.rsp_valid, 1'b0);
    step();                                   // E2: TURN
    bus.ack = 1'b0;
    chk1("wr_rsp_valid", bus.rsp_valid, 1'b1);
    chk1("wr_rsp_err",   bus.rsp_err,   1'b0);
    chk ("wr_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk1("wr_turn_wr_n", bus.wr_n,      1'b1);
    chk1("wr_turn_oe",   bus.ad_oe_n,   1'b1);
    chk ("wr_ad_hold",   bus.ad_out,    32'hDEAD_BEEF);
    step();                                   // E3: IDLE
    chk1("wr_rsp_pulse", bus.rsp_valid, 1'b0);
    chk1("wr_ready_ret", bus.req_ready, 1'b1);

    // Read acked after 3 wait cycles.
    drive_req(1'b0, 32'h0000_0040, 32'hFFFF_0000);
    bus.ad_in = 32'hBAD0_BAD0;
    step();                                   // E0
    bus.req_valid = 1'b0;
    chk ("rd_ad_addr", bus.ad_out, 32'h0000_0040);
    step();                                   // E1: DATA cycle 1
    chk1("rd_rd_n", bus.rd_n,    1'b0);
    chk1("rd_oe_n", bus.ad_oe_n, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();                                 // E2..E4
      chk1("rd_wait_oe_n", bus.ad_oe_n,   1'b1);
      chk1("rd_wait_rd_n", bus.rd_n,      1'b0);
      chk1("rd_wait_rsp",  bus.rsp_valid, 1'b0);
    end
    bus.ack   = 1'b1;
    bus.ad_in = 32'h1234_5678;
    step();                                   // E5: TURN
    bus.ack   = 1'b0;
    bus.ad_in = 32'h0BAD_F00D;
    chk1("rd_rsp_valid", bus.rsp_valid, 1'b1);
    chk1("rd_rsp_err",   bus.rsp_err,   1'b0);
    chk ("rd_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    chk1("rd_turn_rd_n", bus.rd_n,      1'b1);
    step();                                   // E6
    chk1("rd_rsp_pulse", bus.rsp_valid, 1'b0);
    chk ("rd_rdata_hold", bus.rsp_rdata, 32'h1234_5678);
    chk1("rd_ready_ret", bus.req_ready, 1'b1);

    // Timeout: ack never arrives.
    drive_req(1'b0, 32'h0000_0080, 32'h0);
    step();                                   // E0
    bus.req_valid = 1'b0;
    step();                                   // E1: DATA cycle 1
    for (int i = 0; i < 14; i++) begin
      step();                                 // E2..E15
      chk1("to_wait_rsp",  bus.rsp_valid, 1'b0);
      chk1("to_wait_rd_n", bus.rd_n,      1'b0);
    end
    step();                                   // E16: after 15 DATA cycles
    chk1("to_rsp_valid", bus.rsp_valid, 1'b1);
    chk1("to_rsp_err",   bus.rsp_err,   1'b1);
    chk ("to_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk1("to_rd_n_rel",  bus.rd_n,      1'b1);
    step();
    chk1("to_rsp_pulse", bus.rsp_valid, 1'b0);

    // Ack in the 15th (last allowed) DATA cycle.
    drive_req(1'b0, 32'h0000_00C0, 32'h0);
    step();                                   // E0
    bus.req_valid = 1'b0;
    step();                                   // E1
    for (int i = 0; i < 14; i++) begin
      step();                                 // E2..E15
      chk1("last_wait_rsp", bus.rsp_valid, 1'b0);
    end
    bus.ack   = 1'b1;
    bus.ad_in = 32'hA5A5_0F0F;
    step();                                   // E16
    bus.ack = 1'b0;
    chk1("last_rsp_valid", bus.rsp_valid, 1'b1);
    chk1("last_rsp_err",   bus.rsp_err,   1'b0);
    chk ("last_rsp_rdata", bus.rsp_rdata, 32'hA5A5_0F0F);
    step();
    chk1("last_ready", bus.req_ready, 1'b1);

    // Back-to-back with req_valid held high and a zero-wait target.
    bus.ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_req((i != 1), b2b_addr[i], b2b_data[i]);
      bus.ad_in = 32'h3333_4444;
      step();                                 // E0
      chk1("b2b_ale",      bus.ale,       1'b1);
      chk ("b2b_addr",     bus.ad_out,    b2b_addr[i]);
      chk1("b2b_ready_e0", bus.req_ready, 1'b0);
      step();                                 // E1
      chk1("b2b_ready_e1", bus.req_ready, 1'b0);
      step();                                 // E2
      chk1("b2b_ready_e2", bus.req_ready, 1'b0);
      chk1("b2b_rsp",      bus.rsp_valid, 1'b1);
      chk ("b2b_rdata",    bus.rsp_rdata, b2b_rexp[i]);
      step();                                 // E3
      chk1("b2b_ready_e3", bus.req_ready, 1'b1);
      chk1("b2b_rsp_low",  bus.rsp_valid, 1'b0);
    end
    bus.req_valid = 1'b0;
    bus.ack       = 1'b0;
    step();
    chk1("b2b_idle_ale", bus.ale, 1'b0);

    // Reset in the middle of a write data phase.
    drive_req(1'b1, 32'h0000_2000, 32'h0F0F_F0F0);
    step();                                   // E0
    bus.req_valid = 1'b0;
    step();                                   // E1: DATA
    step();                                   // E2: still DATA
    chk1("mid_wr_n_active", bus.wr_n, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk1("mid_oe_released", bus.ad_oe_n,   1'b1);
    chk1("mid_wr_released", bus.wr_n,      1'b1);
    chk1("mid_no_rsp",      bus.rsp_valid, 1'b0);
    chk1("mid_ready_low",   bus.req_ready, 1'b0);
    step(); step();
    chk1("mid_still_no_rsp", bus.rsp_valid, 1'b0);
    reset_n = 1'b1;
    step();
    chk1("post_rst_ready", bus.req_ready, 1'b1);
    drive_req(1'b0, 32'h0000_3000, 32'h0);
    step();                                   // E0
    bus.req_valid = 1'b0;
    bus.ack       = 1'b1;
    bus.ad_in     = 32'hCAFE_F00D;
    chk ("post_rst_addr", bus.ad_out, 32'h0000_3000);
    step();                                   // E1
    step();                                   // E2
    bus.ack = 1'b0;
    chk1("post_rst_rsp",   bus.rsp_valid, 1'b1);
    chk1("post_rst_err",   bus.rsp_err,   1'b0);
    chk ("post_rst_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    step();
    chk1("post_rst_ready2", bus.req_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
